// File: rtl/sr_drive_pkg.sv
// Shared types and drive encodings for the SR flip-flop command driver.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE
  } state_e;

  // {s, r} drive encodings; s and r are never both high.
  localparam logic [1:0] DRV_NONE = 2'b00;
  localparam logic [1:0] DRV_SET  = 2'b10;
  localparam logic [1:0] DRV_RST  = 2'b01;

  function automatic logic [1:0] drv_for(input logic level);
    return level ? DRV_SET : DRV_RST;
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous request FIFO holding 1-bit target levels.
module sr_cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       din,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Turns queued level requests into legal, fixed-width set/reset pulses for an
// SR flip-flop and checks the flip-flop's q against the expected level.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic fb_q,
  output logic q_shadow,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    drv_q, drv_d;
  logic          target_q, target_d;
  logic          shadow_q, shadow_d;
  logic          err_q, err_d;

  logic          fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign fifo_push = req_valid && !fifo_full;
  assign req_ready = !fifo_full;

  sr_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (req_level),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign {s, r}   = drv_q;
  assign q_shadow = shadow_q;
  assign err      = err_q;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

  // Next-state: pop and decide in IDLE, time the pulse, then check feedback.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    drv_d    = drv_q;
    target_d = target_q;
    shadow_d = shadow_q;
    err_d    = err_q && !err_clr;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          target_d = fifo_dout;
          // A request matching the current level is consumed without a pulse.
          if (fifo_dout != shadow_q) begin
            hold_d  = HW'(HOLD_CYCLES);
            drv_d   = drv_for(fifo_dout);
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) begin
          drv_d   = DRV_NONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        shadow_d = target_q;
        // A fresh mismatch overrides a simultaneous clear.
        if (fb_q != target_q) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops the drive at once and abandons any pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      drv_q    <= DRV_NONE;
      target_q <= 1'b0;
      shadow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      drv_q    <= drv_d;
      target_q <= target_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

endmodule
